// File: rtl/snake_pkg.sv
// Shared encodings for the snake game control path: turn FSM states and
// winner codes, plus the score comparison used to declare a winner.
package snake_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM1    = 3'd1,
    ST_P1_PLAY = 3'd2,
    ST_P1_DONE = 3'd3,
    ST_ARM2    = 3'd4,
    ST_P2_PLAY = 3'd5,
    ST_P2_DONE = 3'd6,
    ST_RESULT  = 3'd7
  } state_e;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;
  localparam logic [1:0] WIN_TIE  = 2'd3;

  function automatic logic [1:0] pick_winner(input logic [7:0] a, input logic [7:0] b);
    if (a > b)      return WIN_P1;
    else if (b > a) return WIN_P2;
    else            return WIN_TIE;
  endfunction

endpackage

// File: rtl/round_timer.sv
// Per-round tick budget: reloads while armed, counts ticks down while a round
// is live, and flags the tick that exhausts the budget.
module round_timer #(
  parameter int unsigned ROUND_TICKS = 600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        run,
  input  logic        tick,
  output logic [15:0] time_left,
  output logic        expire
);

  localparam logic [15:0] LOAD_VAL = 16'(ROUND_TICKS);

  logic [15:0] time_left_q, time_left_d;

  // The expiring tick does not decrement, so the display freezes on 1.
  assign expire    = run & tick & (time_left_q == 16'd1);
  assign time_left = time_left_q;

  always_comb begin
    time_left_d = time_left_q;
    if (load)
      time_left_d = LOAD_VAL;
    else if (run && tick && !expire)
      time_left_d = time_left_q - 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) time_left_q <= LOAD_VAL;
    else      time_left_q <= time_left_d;
  end

endmodule

// File: rtl/turn_controller.sv
// Two-player round sequencer: arms each round, runs it until collision or
// timeout, pauses for display, latches scores and declares the winner.
module turn_controller
  import snake_pkg::*;
#(
  parameter int unsigned ROUND_TICKS = 600,
  parameter int unsigned HOLD_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        tick,
  input  logic        collision,
  input  logic [7:0]  score,
  output logic        score_reset,
  output logic        game_run,
  output logic        active_player,
  output logic [15:0] time_left,
  output logic [7:0]  p1_score,
  output logic [7:0]  p2_score,
  output logic [7:0]  high_score,
  output logic [1:0]  winner,
  output logic [2:0]  state
);

  localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] hold_q, hold_d;
  logic [7:0]  p1_q, p1_d, p2_q, p2_d, hi_q, hi_d;
  logic [1:0]  win_q, win_d;
  logic        in_play, in_arm, expire, hold_last;
  logic [7:0]  hi_next;

  assign in_play   = (state_q == ST_P1_PLAY) || (state_q == ST_P2_PLAY);
  assign in_arm    = (state_q == ST_ARM1) || (state_q == ST_ARM2);
  assign hold_last = (hold_q == HOLD_LAST);
  assign hi_next   = (score > hi_q) ? score : hi_q;

  round_timer #(.ROUND_TICKS(ROUND_TICKS)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (in_arm),
    .run       (in_play),
    .tick      (tick),
    .time_left (time_left),
    .expire    (expire)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = '0;
    p1_d    = p1_q;
    p2_d    = p2_q;
    hi_d    = hi_q;
    win_d   = win_q;
    case (state_q)
      ST_IDLE, ST_RESULT: if (start) begin
        state_d = ST_ARM1;
        p1_d    = '0;
        p2_d    = '0;
        win_d   = WIN_NONE;
      end
      ST_ARM1:    state_d = ST_P1_PLAY;
      ST_P1_PLAY: if (collision || expire) state_d = ST_P1_DONE;
      ST_P1_DONE: begin
        hold_d = hold_q + 32'd1;
        if (hold_last) begin
          hold_d  = '0;
          p1_d    = score;
          hi_d    = hi_next;
          state_d = ST_ARM2;
        end
      end
      ST_ARM2:    state_d = ST_P2_PLAY;
      ST_P2_PLAY: if (collision || expire) state_d = ST_P2_DONE;
      ST_P2_DONE: begin
        hold_d = hold_q + 32'd1;
        if (hold_last) begin
          // Winner is judged against the score being latched on this same edge.
          hold_d  = '0;
          p2_d    = score;
          hi_d    = hi_next;
          win_d   = pick_winner(p1_q, score);
          state_d = ST_RESULT;
        end
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      hi_q    <= '0;
      win_q   <= WIN_NONE;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      hi_q    <= hi_d;
      win_q   <= win_d;
    end
  end

  assign score_reset   = in_arm;
  assign game_run      = in_play;
  assign active_player = (state_q == ST_ARM2) || (state_q == ST_P2_PLAY) ||
                         (state_q == ST_P2_DONE) || (state_q == ST_RESULT);
  assign p1_score      = p1_q;
  assign p2_score      = p2_q;
  assign high_score    = hi_q;
  assign winner        = win_q;
  assign state         = state_q;

endmodule

// File: tb/tb_turn_controller.sv
// Randomized bench for turn_controller: a round-level model predicts every
// state visit and its outputs; a monitor checks each state change in order.
module tb_turn_controller;

  localparam int RT = 5;
  localparam int HC = 4;

  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, tick = 1'b0, collision = 1'b0;
  logic [7:0]  score = 8'd0;
  logic        score_reset, game_run, active_player;
  logic [15:0] time_left;
  logic [7:0]  p1_score, p2_score, high_score;
  logic [1:0]  winner;
  logic [2:0]  state;

  turn_controller #(.ROUND_TICKS(RT), .HOLD_CYCLES(HC)) dut (
    .clk(clk), .rst(rst), .start(start), .tick(tick), .collision(collision),
    .score(score), .score_reset(score_reset), .game_run(game_run),
    .active_player(active_player), .time_left(time_left), .p1_score(p1_score),
    .p2_score(p2_score), .high_score(high_score), .winner(winner), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st; int sr; int gr; int ap; int tl; int p1; int p2; int hi; int win; int dwell;
  } exp_t;

  exp_t q[$];
  int checks = 0, failures = 0;
  int hi_m = 0, p1_m = 0;

  task automatic push(input int st, input int sr, input int gr, input int ap, input int tl,
                      input int p1, input int p2, input int hi, input int win, input int dwell);
    exp_t e;
    e.st = st; e.sr = sr; e.gr = gr; e.ap = ap; e.tl = tl;
    e.p1 = p1; e.p2 = p2; e.hi = hi; e.win = win; e.dwell = dwell;
    q.push_back(e);
  endtask

  // Monitor: every state change must match the next predicted visit.
  initial begin
    int prev = -1, cnt = 0, exp_dwell = -1;
    exp_t e;
    bit ok;
    forever begin
      @(negedge clk);
      if (int'(state) != prev) begin
        if (prev >= 0 && exp_dwell >= 0) begin
          checks++;
          if (cnt != exp_dwell) begin
            failures++;
            $display("FAIL dwell st=%0d got=%0d want=%0d", prev, cnt, exp_dwell);
          end
        end
        checks++;
        if (q.size() == 0) begin
          failures++;
          exp_dwell = -1;
          $display("FAIL unexpected_state got=%0d want=none t=%0t", state, $time);
        end else begin
          e = q.pop_front();
          ok = (int'(state) == e.st) && (int'(score_reset) == e.sr) && (int'(game_run) == e.gr) &&
               (int'(active_player) == e.ap) && (e.tl < 0 || int'(time_left) == e.tl) &&
               (int'(p1_score) == e.p1) && (int'(p2_score) == e.p2) &&
               (int'(high_score) == e.hi) && (int'(winner) == e.win);
          if (!ok) begin
            failures++;
            $display("FAIL visit got st=%0d sr=%0d run=%0d ap=%0d tl=%0d p1=%0d p2=%0d hi=%0d win=%0d want st=%0d sr=%0d run=%0d ap=%0d tl=%0d p1=%0d p2=%0d hi=%0d win=%0d",
                     state, score_reset, game_run, active_player, time_left, p1_score, p2_score,
                     high_score, winner, e.st, e.sr, e.gr, e.ap, e.tl, e.p1, e.p2, e.hi, e.win);
          end
          exp_dwell = e.dwell;
        end
        prev = int'(state);
        cnt  = 1;
      end else begin
        cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic noise(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'($urandom_range(0, 1));
      collision = 1'($urandom_range(0, 1));
      start = 1'b0;
      step();
    end
    tick = 1'b0; collision = 1'b0;
  endtask

  task automatic start_game();
    push(1, 1, 0, 0, -1, 0, 0, hi_m, 0, 1);
    push(2, 0, 1, 0, RT, 0, 0, hi_m, 0, -1);
    start = 1'b1; step();
    start = 1'b0; step();
  endtask

  // One round from its first PLAY cycle through the display pause.
  task automatic play_round(input int pl, input int col_tick, input int sval,
                            input int abort_k, input bit gap);
    int rem = RT, nt = 0, cyc = 0, tl_end = 0, newhi, w;
    bit fin = 1'b0, t, c;
    while (!fin) begin
      t = (cyc >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
      c = 1'b0;
      if (t) begin
        nt++;
        if (col_tick == nt) c = 1'b1;
      end else if (gap && col_tick > 0 && nt == col_tick - 1 && $urandom_range(0, 3) == 0) begin
        c = 1'b1;
      end
      tick = t; collision = c; score = 8'(sval);
      start = ($urandom_range(0, 3) == 0);
      if (c || (t && rem == 1)) begin
        fin = 1'b1;
        tl_end = (t && rem == 1) ? 1 : (t ? rem - 1 : rem);
      end else if (t) begin
        rem--;
      end
      if (fin) begin
        newhi = (sval > hi_m) ? sval : hi_m;
        if (pl == 1) begin
          push(3, 0, 0, 0, tl_end, 0, 0, hi_m, 0, HC);
          push(4, 1, 0, 1, -1, sval, 0, newhi, 0, 1);
          push(5, 0, 1, 1, RT, sval, 0, newhi, 0, -1);
          p1_m = sval; hi_m = newhi;
        end else begin
          w = (p1_m > sval) ? 1 : (p1_m < sval) ? 2 : 3;
          push(6, 0, 0, 1, tl_end, p1_m, 0, hi_m, 0, (abort_k > 0) ? -1 : HC);
          if (abort_k == 0) begin
            push(7, 0, 0, 1, tl_end, p1_m, sval, newhi, w, -1);
            hi_m = newhi;
          end
        end
      end
      cyc++;
      step();
    end
    for (int k = 1; k <= HC + 1; k++) begin
      if (k == abort_k) begin
        push(0, 0, 0, 0, RT, 0, 0, 0, 0, -1);
        rst = 1'b0; hi_m = 0; p1_m = 0;
        tick = 1'b0; collision = 1'b0; start = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        return;
      end
      tick = 1'($urandom_range(0, 1));
      collision = 1'($urandom_range(0, 1));
      start = (pl == 2 && k == HC + 1) ? 1'b0 : 1'($urandom_range(0, 1));
      score = (k < HC) ? 8'($urandom_range(0, 255)) : (k == HC) ? 8'(sval) : 8'd0;
      step();
    end
    tick = 1'b0; collision = 1'b0; start = 1'b0;
  endtask

  task automatic run_game(input int s1, input int c1, input int s2, input int c2,
                          input int abort_k, input bit gap);
    start_game();
    play_round(1, c1, s1, 0, gap);
    play_round(2, c2, s2, abort_k, gap);
    tick = 1'b0; collision = 1'b0; start = 1'b0;
  endtask

  initial begin
    push(0, 0, 0, 0, RT, 0, 0, 0, 0, -1);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    noise(6);
    run_game(7, 0, 3, 2, 0, 1'b0);
    noise(3);
    run_game(4, RT, 4, RT, 0, 1'b0);
    for (int i = 0; i < 4; i++)
      run_game($urandom_range(0, 255), $urandom_range(0, RT),
               $urandom_range(0, 255), $urandom_range(0, RT), 0, 1'b1);
    run_game($urandom_range(0, 255), $urandom_range(0, RT),
             $urandom_range(0, 255), $urandom_range(0, RT), 2, 1'b1);
    noise(4);
    run_game($urandom_range(0, 255), $urandom_range(0, RT),
             $urandom_range(0, 255), $urandom_range(0, RT), 0, 1'b1);
    repeat (5) step();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL pending_visits got=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
